// File: rtl/urv_imem_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : urv_imem_arb_if                                                 |
// | Purpose  : Bundles the fetch, host/loader and instruction-memory buses of  |
// |            the uRV instruction-memory arbiter.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Signals (directions as seen by the arbiter, modport slave)                 |
// |   f_im_addr_i   in  32  fetch address (pc_next)                            |
// |   f_idle_i      in   1  fetch not consuming; host may be granted at once   |
// |   f_im_data_o   out 32  memory read data passed to fetch                   |
// |   f_im_valid_o  out  1  fetch read data valid this cycle                   |
// |   h_req_i       in   1  host request, held stable until h_ack_o            |
// |   h_we_i        in   1  host write                                         |
// |   h_addr_i      in  32  host word-aligned byte address                     |
// |   h_wdata_i     in  32  host write data                                    |
// |   h_ack_o       out  1  one-cycle host completion pulse                    |
// |   h_rdata_o     out 32  registered host read data, valid with h_ack_o      |
// |   mem_addr_o    out 32  memory address                                     |
// |   mem_wdata_o   out 32  memory write data                                  |
// |   mem_we_o      out  1  memory write strobe                                |
// |   mem_data_i    in  32  memory read data for previous cycle's address      |
// | Modports : slave  - the arbiter                                            |
// |            master - the environment (fetch unit, host, memory)             |
// +----------------------------------------------------------------------------+
interface urv_imem_arb_if;
  // fetch side
  logic [31:0] f_im_addr_i;
  logic        f_idle_i;
  logic [31:0] f_im_data_o;
  logic        f_im_valid_o;
  // host / loader side
  logic        h_req_i;
  logic        h_we_i;
  logic [31:0] h_addr_i;
  logic [31:0] h_wdata_i;
  logic        h_ack_o;
  logic [31:0] h_rdata_o;
  // memory side
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  f_im_addr_i, f_idle_i, h_req_i, h_we_i, h_addr_i, h_wdata_i, mem_data_i,
    output f_im_data_o, f_im_valid_o, h_ack_o, h_rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
  );

  modport master (
    output f_im_addr_i, f_idle_i, h_req_i, h_we_i, h_addr_i, h_wdata_i, mem_data_i,
    input  f_im_data_o, f_im_valid_o, h_ack_o, h_rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
  );
endinterface
`default_nettype wire

// File: rtl/urv_imem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : urv_imem_arb                                                    |
// | Purpose  : Shares the single-port, 1-cycle-latency instruction memory      |
// |            between the uRV fetch unit and a host/loader port. Fetch owns   |
// |            the memory by default; a host transaction steals one memory     |
// |            cycle, which fetch sees as a single f_im_valid_o low cycle.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   HOST_WAIT  max cycles a pending host request waits while fetch is busy   |
// |              (1..15, default 4)                                            |
// | Ports                                                                      |
// |   clk_i      clock                                                         |
// |   rst_n_i    asynchronous active-low reset                                 |
// |   bus        urv_imem_arb_if.slave: fetch, host and memory buses           |
// | Build option                                                               |
// |   URV_IMEM_HOST_WRITE_EN  defined  : host writes reach the memory          |
// |                           undefined: mem_we_o tied low, host writes are    |
// |                           sequenced and acked but do not modify memory,    |
// |                           and h_rdata_o returns the current memory word    |
// +----------------------------------------------------------------------------+
module urv_imem_arb #(
  parameter int unsigned HOST_WAIT = 4
) (
  input logic           clk_i,
  input logic           rst_n_i,
  urv_imem_arb_if.slave bus
);

  localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // fetch drives the memory
    ISSUE = 2'd1,  // host drives the memory for exactly one cycle
    CAPT  = 2'd2,  // host data returns; fetch owns the memory again
    ACK   = 2'd3   // host completion pulse
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        started;   // low only until the first clock edge after reset release
  logic        f_valid;
  logic        h_ack;
  logic [31:0] h_rdata;

  logic        grant;
  logic        host_cycle;
  logic        host_we;
  logic        capture;

  // Host wins immediately when fetch is idle, otherwise once it has waited
  // its full budget. The request is only looked at in FETCH, so a request
  // still high in the cycle after ACK starts a fresh transaction.
  assign grant      = (state == FETCH) && bus.h_req_i &&
                      (bus.f_idle_i || (wait_cnt >= WAIT_MAX));
  assign host_cycle = (state == ISSUE);

`ifdef URV_IMEM_HOST_WRITE_EN
  assign host_we = host_cycle && bus.h_we_i;
  // Writes leave the previously returned read data untouched.
  assign capture = !bus.h_we_i;
`else
  logic unused_h_we;
  assign unused_h_we = bus.h_we_i;
  assign host_we     = 1'b0;
  // With writes disabled every host access behaves as a read of the
  // addressed word, including the would-be writes.
  assign capture     = 1'b1;
`endif

  // Memory ownership follows the state register only, so mem_we_o drops
  // the moment reset asserts (state is forced back to FETCH).
  assign bus.mem_addr_o  = host_cycle ? bus.h_addr_i : bus.f_im_addr_i;
  assign bus.mem_wdata_o = bus.h_wdata_i;
  assign bus.mem_we_o    = host_we;

  assign bus.f_im_data_o  = bus.mem_data_i;
  assign bus.f_im_valid_o = f_valid;
  assign bus.h_ack_o      = h_ack;
  assign bus.h_rdata_o    = h_rdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= FETCH;
      wait_cnt <= 4'd0;
      started  <= 1'b0;
      f_valid  <= 1'b0;
      h_ack    <= 1'b0;
      h_rdata  <= 32'd0;
    end else begin
      started <= 1'b1;
      // Fetch data is valid whenever fetch owned the memory in the cycle
      // that produced it; only the ISSUE cycle belongs to the host. The
      // very first cycle after reset release is never reported valid.
      f_valid <= started && (state != ISSUE);
      h_ack   <= 1'b0;

      case (state)
        FETCH: begin
          if (grant) begin
            state    <= ISSUE;
            wait_cnt <= 4'd0;
          end else if (bus.h_req_i) begin
            if (wait_cnt < WAIT_MAX) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            wait_cnt <= 4'd0;
          end
        end

        ISSUE: begin
          state <= CAPT;
        end

        CAPT: begin
          state <= ACK;
          h_ack <= 1'b1;
          if (capture) begin
            h_rdata <= bus.mem_data_i;
          end
        end

        ACK: begin
          state <= FETCH;
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_urv_imem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_urv_imem_arb                                                 |
// | Purpose  : Self-checking bench for urv_imem_arb with a behavioural         |
// |            1-cycle-latency memory, a fetch scoreboard and a host scoreboard|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_urv_imem_arb;

  localparam int HOST_WAIT = 4;
`ifdef URV_IMEM_HOST_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  urv_imem_arb_if bus ();

  urv_imem_arb #(.HOST_WAIT(HOST_WAIT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  fent_t       fq[$];          // fetch: address presented and word expected back
  logic [31:0] hq[$];          // host: expected h_rdata_o at each ack
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem     [0:255];
  logic [31:0] pc;
  logic [31:0] last_rdata;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEADBEEF;   // byte address 0x100
    return 32'h5A00_0000 | 32'(i);
  endfunction

  // Behavioural single-port memory, registered read (read-old on collision).
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    bus.mem_data_i = 32'd0;
    forever begin
      @(posedge clk);
      bus.mem_data_i <= mem[bus.mem_addr_o[9:2]];
      if (bus.mem_we_o === 1'b1) mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock of the fetch unit: sample after the edge, score the returned
  // word, then present the next (or the same, if invalid) address.
  task automatic run_cycle(input bit br, input logic [31:0] tgt);
    fent_t fe;
    @(posedge clk);
    #1;
    if (fq.size() > 0) begin
      fe = fq.pop_front();
      if (bus.f_im_valid_o === 1'b1) begin
        n_checks++;
        if (bus.f_im_data_o !== fe.data) begin
          n_fail++;
          $display("FAIL fetch_data addr %h: got %h expected %h", fe.addr, bus.f_im_data_o, fe.data);
        end
        pc = fe.addr + 32'd4;
      end else begin
        pc = fe.addr;
      end
    end
    if (br) pc = tgt;
    pc = pc & 32'h0000_03FC;
    bus.f_im_addr_i = pc;
    fq.push_back('{addr: pc, data: ref_mem[pc[9:2]]});
    #1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.f_im_addr_i = 32'd0;
    bus.f_idle_i    = 1'b0;
    bus.h_req_i     = 1'b0;
    bus.h_we_i      = 1'b0;
    bus.h_addr_i    = 32'd0;
    bus.h_wdata_i   = 32'd0;
    pc              = 32'd0;
    last_rdata      = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.f_im_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.f_im_valid_o); end
    n_checks++;
    if (bus.h_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.h_ack_o); end
    n_checks++;
    if (bus.h_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.h_rdata_o); end
    n_checks++;
    if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.mem_we_o); end
    rst_n = 1'b1;
    fq.push_back('{addr: 32'd0, data: ref_mem[0]});
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b0, 32'd0);
      n_checks++;
      if (bus.f_im_valid_o !== (i != 0)) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d: got %b expected %b", i, bus.f_im_valid_o, (i != 0));
      end
      n_checks++;
      if (bus.mem_addr_o !== pc) begin
        n_fail++;
        $display("FAIL stream_addr cycle %0d: got %h expected %h", i, bus.mem_addr_o, pc);
      end
    end
  endtask

  // Single host transaction; grant/ack cycles are predicted from idle/HOST_WAIT.
  task automatic host_xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit idle);
    int issue_it;
    int ack_it;
    bit seen;
    logic [31:0] exp;
    issue_it = idle ? 1 : HOST_WAIT + 1;
    ack_it   = issue_it + 2;
    seen     = 1'b0;
    run_cycle(1'b0, 32'd0);
    bus.f_idle_i  = idle;
    bus.h_req_i   = 1'b1;
    bus.h_we_i    = we;
    bus.h_addr_i  = addr;
    bus.h_wdata_i = wdata;
    hq.push_back((we && WRITE_EN) ? last_rdata : ref_mem[addr[9:2]]);
    for (int it = 1; it <= ack_it + 1; it++) begin
      run_cycle(1'b0, 32'd0);
      if (it == issue_it) begin
        n_checks++;
        if (bus.mem_addr_o !== addr) begin n_fail++; $display("FAIL host_addr: got %h expected %h", bus.mem_addr_o, addr); end
        n_checks++;
        if (bus.mem_we_o !== (we && WRITE_EN)) begin n_fail++; $display("FAIL host_we: got %b expected %b", bus.mem_we_o, (we && WRITE_EN)); end
      end
      n_checks++;
      if (bus.f_im_valid_o !== (it != issue_it + 1)) begin
        n_fail++;
        $display("FAIL host_fvalid it %0d: got %b expected %b", it, bus.f_im_valid_o, (it != issue_it + 1));
      end
      n_checks++;
      if (bus.h_ack_o !== (it == ack_it)) begin
        n_fail++;
        $display("FAIL host_ack it %0d: got %b expected %b", it, bus.h_ack_o, (it == ack_it));
      end
      if (bus.h_ack_o === 1'b1 && !seen && hq.size() > 0) begin
        seen = 1'b1;
        exp  = hq.pop_front();
        n_checks++;
        if (bus.h_rdata_o !== exp) begin n_fail++; $display("FAIL host_rdata: got %h expected %h", bus.h_rdata_o, exp); end
        last_rdata  = exp;
        bus.h_req_i = 1'b0;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL host_timeout: got no ack expected ack within %0d cycles", ack_it + 1);
      bus.h_req_i = 1'b0;
      hq.delete();
    end
    if (we && WRITE_EN) ref_mem[addr[9:2]] = wdata;
    bus.f_idle_i = 1'b0;
  endtask

  task automatic test_host_read_idle();
    host_xact(1'b0, 32'h100, 32'd0, 1'b1);
  endtask

  task automatic test_host_read_busy();
    host_xact(1'b0, 32'h0C4, 32'd0, 1'b0);
  endtask

  task automatic test_host_write();
    logic [31:0] exp_w;
    run_cycle(1'b1, 32'h200);
    host_xact(1'b1, 32'h020, 32'h12345678, 1'b1);
    exp_w = WRITE_EN ? 32'h12345678 : 32'h5A00_0008;
    run_cycle(1'b1, 32'h020);
    run_cycle(1'b0, 32'd0);
    n_checks++;
    if (bus.f_im_valid_o !== 1'b1 || bus.f_im_data_o !== exp_w) begin
      n_fail++;
      $display("FAIL write_fetch: got %h (valid %b) expected %h", bus.f_im_data_o, bus.f_im_valid_o, exp_w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    run_cycle(1'b1, 32'h300);
    bus.f_idle_i = 1'b1;
    bus.h_req_i  = 1'b1;
    bus.h_we_i   = 1'b0;
    bus.h_addr_i = 32'h100;
    repeat (3) hq.push_back(ref_mem[32'h40]);
    for (int it = 1; it <= 13; it++) begin
      run_cycle(1'b0, 32'd0);
      n_checks++;
      if (bus.f_im_valid_o !== !(it <= 11 && it % 4 == 2)) begin
        n_fail++;
        $display("FAIL b2b_fvalid it %0d: got %b expected %b", it, bus.f_im_valid_o, !(it <= 11 && it % 4 == 2));
      end
      n_checks++;
      if (bus.h_ack_o !== (it <= 11 && it % 4 == 3)) begin
        n_fail++;
        $display("FAIL b2b_ack it %0d: got %b expected %b", it, bus.h_ack_o, (it <= 11 && it % 4 == 3));
      end
      if (bus.h_ack_o === 1'b1 && hq.size() > 0) begin
        exp = hq.pop_front();
        n_checks++;
        if (bus.h_rdata_o !== exp) begin n_fail++; $display("FAIL b2b_rdata it %0d: got %h expected %h", it, bus.h_rdata_o, exp); end
        last_rdata = exp;
      end
      if (it == 11) bus.h_req_i = 1'b0;
    end
    n_checks++;
    if (hq.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d acks expected 3", 3 - hq.size());
      hq.delete();
    end
    bus.h_req_i  = 1'b0;
    bus.f_idle_i = 1'b0;
  endtask

  task automatic test_reset_in_capt();
    run_cycle(1'b0, 32'd0);
    bus.f_idle_i = 1'b1;
    bus.h_req_i  = 1'b1;
    bus.h_we_i   = 1'b0;
    bus.h_addr_i = 32'h0C0;
    run_cycle(1'b0, 32'd0);   // ISSUE
    run_cycle(1'b0, 32'd0);   // CAPT
    n_checks++;
    if (bus.f_im_valid_o !== 1'b0) begin n_fail++; $display("FAIL capt_fvalid: got %b expected 0", bus.f_im_valid_o); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.h_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", bus.h_ack_o); end
    n_checks++;
    if (bus.h_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", bus.h_rdata_o); end
    n_checks++;
    if (bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== pc) begin
      n_fail++;
      $display("FAIL rst_mem: got we %b addr %h expected we 0 addr %h", bus.mem_we_o, bus.mem_addr_o, pc);
    end
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 32'd0);
      n_checks++;
      if (bus.h_ack_o !== 1'b0 || bus.f_im_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_hold %0d: got ack %b valid %b expected 0 0", i, bus.h_ack_o, bus.f_im_valid_o);
      end
    end
    bus.h_req_i  = 1'b0;
    bus.f_idle_i = 1'b0;
    last_rdata   = 32'd0;
    rst_n        = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 32'd0);
      n_checks++;
      if (bus.f_im_valid_o !== (i != 0) || bus.h_ack_o !== 1'b0) begin
        n_fail++;
        $display("FAIL resume %0d: got valid %b ack %b expected valid %b ack 0", i, bus.f_im_valid_o, bus.h_ack_o, (i != 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_host_read_idle();
    test_host_read_busy();
    test_host_write();
    test_back_to_back();
    test_reset_in_capt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
